// File: rtl/data_cache_sa.sv
// N-way set-associative, write-back, write-allocate data cache controller.
// One miss outstanding; the memory side moves one whole line per rq/ack handshake.
module data_cache_sa #(
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 4,
    parameter int WAYS        = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic                          rw_in,
    input  logic [31:0]                   address,
    input  logic [31:0]                   wr_data,
    output logic                          stall,
    output logic                          resp_valid,
    output logic [31:0]                   data_out,
    output logic                          rd_rq,
    output logic [31:0]                   ar_r_addr,
    input  logic                          ar_rd_ack,
    input  logic [8*(2**OFFSET_BITS)-1:0] ar_rd_data,
    output logic                          wr_rq,
    output logic [31:0]                   ar_w_addr,
    output logic [8*(2**OFFSET_BITS)-1:0] ar_w_data,
    input  logic                          ar_wr_ack,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
);
    localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_W   = 8 * (2 ** OFFSET_BITS);
    localparam int WORDS    = LINE_W / 32;
    localparam int SETS     = 2 ** INDEX_BITS;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WORD_W   = OFFSET_BITS - 2;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITEBACK, MISSREPAIR} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
    logic                rw_q, rw_d, refill_q, refill_d, resp_valid_q, resp_valid_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [31:0]         data_out_q, data_out_d, ar_r_addr_q, ar_r_addr_d;
    logic [31:0]         ar_w_addr_q, ar_w_addr_d;
    logic [LINE_W-1:0]   ar_w_data_q, ar_w_data_d;
    logic [31:0]         hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [WAY_W-1:0]    rr_q    [SETS];
    logic [TAG_BITS-1:0] tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0]   data_mem [SETS][WAYS];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [WORD_W-1:0]     word;
    logic                  hit_any, alloc_found, vic_dirty;
    logic [WAY_W-1:0]      hit_way, alloc_way, line_way, rr_n;
    logic [LINE_W-1:0]     hit_line, vic_line, merged, line_wdata;
    logic [TAG_BITS-1:0]   vic_tag;
    logic [31:0]           rd_word;
    logic                  meta_we, rr_we, line_we, tag_we;
    logic [WAYS-1:0]       meta_valid_n, meta_dirty_n;

    assign idx  = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign tag  = addr_q[31 -: TAG_BITS];
    assign word = addr_q[OFFSET_BITS-1:2];

    // Lookup of the latched request plus victim choice: first invalid way, else round-robin.
    always_comb begin
        hit_any     = 1'b0;
        hit_way     = '0;
        hit_line    = '0;
        alloc_found = 1'b0;
        alloc_way   = rr_q[idx];
        vic_line    = '0;
        vic_tag     = '0;
        vic_dirty   = 1'b0;
        rd_word     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
                hit_any  = 1'b1;
                hit_way  = WAY_W'(w);
                hit_line = data_mem[idx][w];
            end
            if (!alloc_found && !valid_q[idx][w]) begin
                alloc_found = 1'b1;
                alloc_way   = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (w == int'(alloc_way)) begin
                vic_line  = data_mem[idx][w];
                vic_tag   = tag_mem[idx][w];
                vic_dirty = valid_q[idx][w] && dirty_q[idx][w];
            end
        end
        merged = hit_line;
        for (int k = 0; k < WORDS; k++) begin
            if (k == int'(word)) begin
                rd_word            = hit_line[k*32 +: 32];
                merged[k*32 +: 32] = wdata_q;
            end
        end
    end

    // Memory handshakes: rd_rq/wr_rq stay high until the cycle their ack is seen high;
    // an ack in the first rq cycle completes it, an ack while rq is low means nothing.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        wdata_d      = wdata_q;
        refill_d     = refill_q;
        victim_d     = victim_q;
        resp_valid_d = 1'b0;
        data_out_d   = data_out_q;
        ar_r_addr_d  = ar_r_addr_q;
        ar_w_addr_d  = ar_w_addr_q;
        ar_w_data_d  = ar_w_data_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        meta_we      = 1'b0;
        meta_valid_n = valid_q[idx];
        meta_dirty_n = dirty_q[idx];
        rr_we        = 1'b0;
        rr_n         = rr_q[idx] + WAY_W'(1);
        line_we      = 1'b0;
        line_way     = hit_way;
        line_wdata   = merged;
        tag_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = address;
                    rw_d     = rw_in;
                    wdata_d  = wr_data;
                    refill_d = 1'b0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (hit_any) begin
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                    // The lookup right after a fill completes the original miss, not a new hit.
                    if (!refill_q) hit_count_d = hit_count_q + 32'd1;
                    if (rw_q) begin
                        data_out_d = rd_word;
                    end else begin
                        line_we = 1'b1;
                        meta_we = 1'b1;
                        for (int w = 0; w < WAYS; w++)
                            if (w == int'(hit_way)) meta_dirty_n[w] = 1'b1;
                    end
                end else begin
                    miss_count_d = miss_count_q + 32'd1;
                    victim_d     = alloc_way;
                    rr_we        = !alloc_found && (WAYS > 1);
                    ar_r_addr_d  = {tag, idx, {OFFSET_BITS{1'b0}}};
                    ar_w_addr_d  = {vic_tag, idx, {OFFSET_BITS{1'b0}}};
                    ar_w_data_d  = vic_line;
                    state_d      = vic_dirty ? WRITEBACK : MISSREPAIR;
                end
            end
            WRITEBACK: begin
                if (ar_wr_ack) begin
                    meta_we = 1'b1;
                    for (int w = 0; w < WAYS; w++)
                        if (w == int'(victim_q)) meta_dirty_n[w] = 1'b0;
                    state_d = MISSREPAIR;
                end
            end
            MISSREPAIR: begin
                if (ar_rd_ack) begin
                    line_we    = 1'b1;
                    line_way   = victim_q;
                    line_wdata = ar_rd_data;
                    tag_we     = 1'b1;
                    meta_we    = 1'b1;
                    for (int w = 0; w < WAYS; w++) begin
                        if (w == int'(victim_q)) begin
                            meta_valid_n[w] = 1'b1;
                            meta_dirty_n[w] = 1'b0;
                        end
                    end
                    refill_d = 1'b1;
                    state_d  = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            refill_q     <= 1'b0;
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            data_out_q   <= '0;
            ar_r_addr_q  <= '0;
            ar_w_addr_q  <= '0;
            ar_w_data_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            refill_q     <= refill_d;
            victim_q     <= victim_d;
            resp_valid_q <= resp_valid_d;
            data_out_q   <= data_out_d;
            ar_r_addr_q  <= ar_r_addr_d;
            ar_w_addr_q  <= ar_w_addr_d;
            ar_w_data_q  <= ar_w_data_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            if (meta_we) begin
                valid_q[idx] <= meta_valid_n;
                dirty_q[idx] <= meta_dirty_n;
            end
            if (rr_we) rr_q[idx] <= rr_n;
        end
    end

    // Line and tag storage carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (line_we && w == int'(line_way)) begin
                data_mem[idx][w] <= line_wdata;
                if (tag_we) tag_mem[idx][w] <= tag;
            end
        end
    end

    assign stall      = (state_q != IDLE);
    assign wr_rq      = (state_q == WRITEBACK);
    assign rd_rq      = (state_q == MISSREPAIR);
    assign resp_valid = resp_valid_q;
    assign data_out   = data_out_q;
    assign ar_r_addr  = ar_r_addr_q;
    assign ar_w_addr  = ar_w_addr_q;
    assign ar_w_data  = ar_w_data_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_data_cache_sa.sv
// Bench for data_cache_sa: default 2-way geometry against a transaction-level cache model,
// plus a direct-mapped 256-bit-line instance checked against hand-computed values.
module tb_data_cache_sa;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT A: INDEX_BITS=8, OFFSET_BITS=4, WAYS=2 ----------------
    logic         a_req_valid, a_rw, a_stall, a_resp_valid;
    logic [31:0]  a_address, a_wr_data, a_data_out;
    logic         a_rd_rq, a_rd_ack, a_wr_rq, a_wr_ack;
    logic [31:0]  a_ar_r_addr, a_ar_w_addr, a_hit_count, a_miss_count;
    logic [127:0] a_rd_data, a_w_data;

    data_cache_sa u_dut_a (
        .clk(clk), .reset(rst), .req_valid(a_req_valid), .rw_in(a_rw),
        .address(a_address), .wr_data(a_wr_data), .stall(a_stall),
        .resp_valid(a_resp_valid), .data_out(a_data_out), .rd_rq(a_rd_rq),
        .ar_r_addr(a_ar_r_addr), .ar_rd_ack(a_rd_ack), .ar_rd_data(a_rd_data),
        .wr_rq(a_wr_rq), .ar_w_addr(a_ar_w_addr), .ar_w_data(a_w_data),
        .ar_wr_ack(a_wr_ack), .hit_count(a_hit_count), .miss_count(a_miss_count)
    );

    // ---------------- DUT B: direct-mapped, 16 sets, 32-byte lines ----------------
    logic         b_req_valid, b_rw, b_stall, b_resp_valid;
    logic [31:0]  b_address, b_wr_data, b_data_out;
    logic         b_rd_rq, b_rd_ack, b_wr_rq, b_wr_ack;
    logic [31:0]  b_ar_r_addr, b_ar_w_addr, b_hit_count, b_miss_count;
    logic [255:0] b_rd_data, b_w_data;

    data_cache_sa #(.INDEX_BITS(4), .OFFSET_BITS(5), .WAYS(1)) u_dut_b (
        .clk(clk), .reset(rst), .req_valid(b_req_valid), .rw_in(b_rw),
        .address(b_address), .wr_data(b_wr_data), .stall(b_stall),
        .resp_valid(b_resp_valid), .data_out(b_data_out), .rd_rq(b_rd_rq),
        .ar_r_addr(b_ar_r_addr), .ar_rd_ack(b_rd_ack), .ar_rd_data(b_rd_data),
        .wr_rq(b_wr_rq), .ar_w_addr(b_ar_w_addr), .ar_w_data(b_w_data),
        .ar_wr_ack(b_wr_ack), .hit_count(b_hit_count), .miss_count(b_miss_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model of DUT A (whole-transaction view) ----------------
    bit           m_valid [256][2];
    bit           m_dirty [256][2];
    logic [19:0]  m_tag   [256][2];
    logic [127:0] m_data  [256][2];
    int           m_rr    [256];
    int           m_hits, m_misses;
    logic [127:0] bmem [logic [31:0]];
    logic [32:0]  exp_q [$];

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        if (bmem.exists(la)) return bmem[la];
        return {la + 32'h3, la + 32'h2, la + 32'h1, la};
    endfunction

    task automatic m_reset();
        for (int s = 0; s < 256; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        m_hits = 0;
        m_misses = 0;
        exp_q.delete();
    endtask

    task automatic m_predict(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                             output bit hit, output bit wb, output logic [31:0] wb_addr,
                             output logic [127:0] wb_data, output logic [31:0] fill_addr,
                             output logic [127:0] fill_data);
        logic [7:0]  s;
        logic [19:0] t;
        int wi, way;
        s = addr[11:4];
        t = addr[31:12];
        wi = int'(addr[3:2]);
        way = -1;
        wb = 1'b0; wb_addr = '0; wb_data = '0; fill_addr = '0; fill_data = '0;
        for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
        hit = (way >= 0);
        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            for (int w = 0; w < 2; w++) if (way < 0 && !m_valid[s][w]) way = w;
            if (way < 0) begin
                way = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % 2;
            end
            if (m_valid[s][way] && m_dirty[s][way]) begin
                wb = 1'b1;
                wb_addr = {m_tag[s][way], s, 4'h0};
                wb_data = m_data[s][way];
                bmem[wb_addr] = wb_data;
            end
            fill_addr = {t, s, 4'h0};
            fill_data = mem_line(fill_addr);
            m_valid[s][way] = 1'b1;
            m_dirty[s][way] = 1'b0;
            m_tag[s][way]   = t;
            m_data[s][way]  = fill_data;
        end
        if (rw) begin
            exp_q.push_back({1'b1, m_data[s][way][wi*32 +: 32]});
        end else begin
            m_data[s][way][wi*32 +: 32] = wd;
            m_dirty[s][way] = 1'b1;
            exp_q.push_back({1'b0, 32'h0});
        end
    endtask

    // ---------------- scoreboard: every response of DUT A ----------------
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst && a_resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                if (e[32]) chk("sb_data_out", a_data_out, e[31:0]);
                chk("sb_hit_count", a_hit_count, m_hits);
                chk("sb_miss_count", a_miss_count, m_misses);
            end
        end
    end

    // ---------------- driver for DUT A ----------------
    int           last_lat;
    bit           last_seen_wb, last_seen_rd;
    logic [31:0]  last_wb_addr, last_rd_addr;
    logic [127:0] last_wb_data;

    task automatic a_access(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                            input int wb_delay, input int rd_delay, input bit poke,
                            input bit abort_wb);
        bit e_hit, e_wb, done, aborted;
        logic [31:0] e_wb_addr, e_fill_addr;
        logic [127:0] e_wb_data, e_fill_data;
        int n, cyc, wbc, rdc, exp_lat;
        m_predict(rw, addr, wd, e_hit, e_wb, e_wb_addr, e_wb_data, e_fill_addr, e_fill_data);
        last_seen_wb = 1'b0; last_seen_rd = 1'b0; last_wb_addr = '0; last_wb_data = '0;
        last_rd_addr = '0; last_lat = 0;
        done = 1'b0; aborted = 1'b0; n = 0; cyc = 0; wbc = 0; rdc = 0;
        @(negedge clk);
        while (a_stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_req", a_stall, 1'b0);
        a_req_valid = 1'b1; a_rw = rw; a_address = addr; a_wr_data = wd;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            a_rd_ack = 1'b0; a_wr_ack = 1'b0; a_req_valid = 1'b0;
            if (a_wr_rq) begin
                if (!last_seen_wb) begin
                    last_seen_wb = 1'b1;
                    last_wb_addr = a_ar_w_addr;
                    last_wb_data = a_w_data;
                    chk("wb_addr", a_ar_w_addr, e_wb_addr);
                    chk("wb_data", a_w_data, e_wb_data);
                    if (abort_wb) begin
                        rst = 1'b1;
                        #1;
                        chk("abort_wr_rq", a_wr_rq, 1'b0);
                        chk("abort_stall", a_stall, 1'b0);
                        chk("abort_hit_count", a_hit_count, 32'd0);
                        chk("abort_miss_count", a_miss_count, 32'd0);
                        m_reset();
                        aborted = 1'b1;
                        done = 1'b1;
                    end
                end else begin
                    chk("wb_addr_stable", a_ar_w_addr, e_wb_addr);
                end
                if (!aborted && wbc == wb_delay) a_wr_ack = 1'b1;
                wbc++;
            end
            if (!aborted && a_rd_rq) begin
                if (!last_seen_rd) begin
                    last_seen_rd = 1'b1;
                    last_rd_addr = a_ar_r_addr;
                    chk("rd_addr", a_ar_r_addr, e_fill_addr);
                    chk("wb_before_fill", last_seen_wb, e_wb);
                end else begin
                    chk("rd_addr_stable", a_ar_r_addr, e_fill_addr);
                    chk("stall_held", a_stall, 1'b1);
                end
                if (rdc == rd_delay) begin
                    a_rd_ack = 1'b1;
                    a_rd_data = e_fill_data;
                end
                if (poke && (rdc == 3 || rdc == 10)) begin
                    a_req_valid = 1'b1;
                    a_rw = rdc[0];
                    a_address = 32'h0000_7770 + 32'(rdc);
                end
                rdc++;
            end
            if (!aborted && a_resp_valid) begin
                done = 1'b1;
                last_lat = cyc;
            end
        end
        if (aborted) begin
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
        end else if (!done) begin
            chk("resp_timeout", 1'b0, 1'b1);
        end else begin
            exp_lat = e_hit ? 2 : 4 + rd_delay + (e_wb ? wb_delay + 1 : 0);
            chk("latency", 32'(last_lat), 32'(exp_lat));
            chk("miss_seen", last_seen_rd, !e_hit);
            chk("wb_seen", last_seen_wb, e_wb);
        end
        #2;
    endtask

    // ---------------- driver for DUT B (hand-computed expectations) ----------------
    task automatic b_read(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_fill, input logic [31:0] exp_data);
        int cyc;
        bit done, seen;
        cyc = 0; done = 1'b0; seen = 1'b0;
        @(negedge clk);
        b_req_valid = 1'b1; b_rw = 1'b1; b_address = addr;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            b_rd_ack = 1'b0;
            if (b_rd_rq) begin
                if (!seen) chk({name, "_fill_addr"}, b_ar_r_addr, exp_fill);
                seen = 1'b1;
                b_rd_ack = 1'b1;
                for (int k = 0; k < 8; k++)
                    b_rd_data[k*32 +: 32] = 32'hA5A5_0000 + b_ar_r_addr + 32'(k);
            end
            if (b_resp_valid) begin
                done = 1'b1;
                chk({name, "_data"}, b_data_out, exp_data);
            end
        end
        chk({name, "_missed"}, seen, 1'b1);
        chk({name, "_done"}, done, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wd;
    } vec_t;

    vec_t mix [7];

    initial begin
        a_req_valid = 0; a_rw = 0; a_address = 0; a_wr_data = 0; a_rd_ack = 0; a_wr_ack = 0;
        a_rd_data = '0;
        b_req_valid = 0; b_rw = 0; b_address = 0; b_wr_data = 0; b_rd_ack = 0; b_wr_ack = 0;
        b_rd_data = '0;
        m_reset();
        bmem[32'h0000_1000] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", a_stall, 1'b0);
        chk("rst_resp_valid", a_resp_valid, 1'b0);
        chk("rst_rd_rq", a_rd_rq, 1'b0);
        chk("rst_wr_rq", a_wr_rq, 1'b0);
        chk("rst_data_out", a_data_out, 32'h0);
        chk("rst_ar_r_addr", a_ar_r_addr, 32'h0);
        chk("rst_ar_w_addr", a_ar_w_addr, 32'h0);
        chk("rst_ar_w_data", a_w_data, 128'h0);
        chk("rst_hit_count", a_hit_count, 32'h0);
        chk("rst_miss_count", a_miss_count, 32'h0);
        chk("rst_b_stall", b_stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // cold read, then write hit and read-back
        a_access(1'b1, 32'h0000_1000, 32'h0, 0, 0, 1'b0, 1'b0);
        chk("lit_first_fill_addr", last_rd_addr, 32'h0000_1000);
        chk("lit_first_no_wb", last_seen_wb, 1'b0);
        chk("lit_first_data", a_data_out, 32'hDEAD_BEEF);
        chk("lit_first_miss_count", a_miss_count, 32'd1);
        a_access(1'b0, 32'h0000_1004, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
        chk("lit_write_hit_latency", 32'(last_lat), 32'd2);
        chk("lit_write_hit_count", a_hit_count, 32'd1);
        a_access(1'b1, 32'h0000_1004, 32'h0, 0, 0, 1'b0, 1'b0);
        chk("lit_readback", a_data_out, 32'h1234_5678);

        // stray acks while idle must do nothing
        @(negedge clk);
        a_rd_ack = 1'b1; a_wr_ack = 1'b1; a_rd_data = '1;
        repeat (2) @(negedge clk);
        chk("stray_ack_stall", a_stall, 1'b0);
        chk("stray_ack_rd_rq", a_rd_rq, 1'b0);
        chk("stray_ack_wr_rq", a_wr_rq, 1'b0);
        a_rd_ack = 1'b0; a_wr_ack = 1'b0;

        // fill both ways of set 0x00, then evict the dirty way 0
        a_access(1'b1, 32'h0000_2000, 32'h0, 0, 2, 1'b0, 1'b0);
        a_access(1'b1, 32'h0000_3000, 32'h0, 3, 1, 1'b0, 1'b0);
        chk("lit_evict_wb_addr", last_wb_addr, 32'h0000_1000);
        chk("lit_evict_wb_data", last_wb_data,
            {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hDEAD_BEEF});
        chk("lit_evict_fill_addr", last_rd_addr, 32'h0000_3000);
        a_access(1'b1, 32'h0000_4000, 32'h0, 0, 0, 1'b0, 1'b0);
        chk("lit_rr_evicts_way1_clean", last_seen_wb, 1'b0);
        a_access(1'b1, 32'h0000_3000, 32'h0, 0, 0, 1'b0, 1'b0);
        chk("lit_way0_kept", last_seen_rd, 1'b0);

        // long fill with ignored requests during the stall
        a_access(1'b1, 32'h0000_5000, 32'h0, 0, 20, 1'b1, 1'b0);

        // mixed traffic in set 0x12 with varying handshake delays
        mix[0] = '{1'b0, 32'h0000_A124, 32'hCAFE_0001};
        mix[1] = '{1'b1, 32'h0000_A124, 32'h0};
        mix[2] = '{1'b0, 32'h0001_A128, 32'hCAFE_0002};
        mix[3] = '{1'b1, 32'h0002_A120, 32'h0};
        mix[4] = '{1'b1, 32'h0001_A128, 32'h0};
        mix[5] = '{1'b0, 32'h0003_A12C, 32'hCAFE_0003};
        mix[6] = '{1'b1, 32'h0000_A124, 32'h0};
        foreach (mix[i])
            a_access(mix[i].rw, mix[i].addr, mix[i].wd, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'b0, 1'b0);
        chk("lit_mix_readback_after_wb", a_data_out, 32'hCAFE_0001);

        // reset in the middle of a writeback
        a_access(1'b0, 32'h0000_1060, 32'hAAAA_0001, 0, 0, 1'b0, 1'b0);
        a_access(1'b1, 32'h0000_2060, 32'h0, 0, 0, 1'b0, 1'b0);
        a_access(1'b1, 32'h0000_3060, 32'h0, 5, 0, 1'b0, 1'b1);
        a_access(1'b1, 32'h0000_1004, 32'h0, 0, 0, 1'b0, 1'b0);
        chk("lit_after_reset_misses", last_seen_rd, 1'b1);
        chk("lit_after_reset_miss_count", a_miss_count, 32'd1);
        chk("lit_after_reset_hit_count", a_hit_count, 32'd0);

        // direct-mapped instance: 0x000 and 0x200 share index 0
        b_read("b0", 32'h0000_001C, 32'h0000_0000, 32'hA5A5_0007);
        b_read("b1", 32'h0000_0208, 32'h0000_0200, 32'hA5A5_0202);
        b_read("b2", 32'h0000_0004, 32'h0000_0000, 32'hA5A5_0001);
        b_read("b3", 32'h0000_021C, 32'h0000_0200, 32'hA5A5_0207);
        chk("b_miss_count", b_miss_count, 32'd4);
        chk("b_hit_count", b_hit_count, 32'd0);
        chk("b_no_wr_rq", b_wr_rq, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_cache_sa.md
Name: data_cache_sa

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache controller.
- Next generation of the direct-mapped data cache golden model: generalised in index/offset width and associativity.
- Adds per-set round-robin replacement, dirty-line writeback and hit/miss performance counters.
- Sits between the core load/store port and the AXI-read/write memory adapter; memory transfers are one full line per handshake.

Parameters:
- INDEX_BITS, 8, set index width (sets = 2^INDEX_BITS).
- OFFSET_BITS, 4, byte offset width within a line (line = 2^OFFSET_BITS bytes, minimum 3).
- WAYS, 2, associativity (power of two, 1..8; WAYS=1 is direct-mapped).
- Derived: TAG_BITS = 32-INDEX_BITS-OFFSET_BITS (20); LINE_W = 8*2^OFFSET_BITS (128); WORDS = LINE_W/32.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request; sampled only while stall=0.
- rw_in  in  1  1 = read, 0 = write.
- address  in  32  byte address; bits [1:0] ignored (word access).
- wr_data  in  32  store data.
- stall  out  1  high whenever the controller is not IDLE.
- resp_valid  out  1  one-cycle pulse completing a request.
- data_out  out  32  load data, valid with resp_valid on reads.
- rd_rq  out  1  line fill request.
- ar_r_addr  out  32  fill line address, offset bits zero.
- ar_rd_ack  in  1  fill done; ar_rd_data valid this cycle.
- ar_rd_data  in  LINE_W  fill line data.
- wr_rq  out  1  writeback request.
- ar_w_addr  out  32  victim line address, offset bits zero.
- ar_w_data  out  LINE_W  victim line data.
- ar_wr_ack  in  1  writeback accepted.
- hit_count  out  32  hits since reset, wraps at 2^32.
- miss_count  out  32  misses since reset, wraps at 2^32.

Behaviour:
- Reset (async): state IDLE; all valid, dirty and round-robin pointers cleared; stall, resp_valid, rd_rq and wr_rq are 0; data_out, ar_* addresses/data and both counters are 0. Data arrays are not cleared.
- IDLE:
  - stall=0.
  - req_valid=1 latches address, rw_in and wr_data, then goes to ACCESS.
- ACCESS (stall=1): compare latched tag against all valid ways of the set.
  - Hit, read: data_out = selected word, resp_valid=1 next cycle, hit_count+1, return to IDLE.
  - Hit, write: merge word into line, set dirty, resp_valid=1 next cycle, hit_count+1, return to IDLE.
  - Hit latency is 2 cycles from the accept edge to the resp_valid cycle.
  - Miss: miss_count+1. Victim is the lowest-numbered invalid way; if all ways are valid, the way at the set's round-robin pointer, which then increments modulo WAYS.
  - Miss, victim dirty: go to WRITEBACK. Otherwise go to MISSREPAIR.
- WRITEBACK:
  - wr_rq=1 with ar_w_addr = {victim tag, index, 0} and ar_w_data = victim line, all held stable.
  - On the cycle ar_wr_ack=1: clear dirty, drop wr_rq next cycle, go to MISSREPAIR.
- MISSREPAIR:
  - rd_rq=1 with ar_r_addr = {tag, index, 0}.
  - On ar_rd_ack=1: write ar_rd_data into the victim way, set valid, dirty=0, tag updated, return to ACCESS.
  - The re-lookup is then a guaranteed hit and completes the request, but does not increment hit_count.
- Acks while the matching rq is low are ignored.
- Ack in the same cycle the rq is first asserted is honoured, giving a minimum of 1 cycle per handshake.
- A request with the same index as the line just filled or updated sees the new data.
- At most one miss is outstanding. req_valid while stall=1 is ignored; it is not queued.
- Reset mid-WRITEBACK or mid-MISSREPAIR drops rq immediately and discards the transaction; the cache comes up empty.
- WAYS=1: victim is always way 0; the pointer is unused.

Test Plan:
- Defaults, after reset: read 0x0000_1000 -> miss_count=1, rd_rq with ar_r_addr=0x0000_1000. Ack with line word0=0xDEADBEEF -> resp_valid with data_out=0xDEADBEEF, no wr_rq.
- Write 0x0000_1004 with 0x12345678 after the fill -> hit, resp_valid 2 cycles after accept, hit_count=1. Read 0x0000_1004 -> 0x12345678.
- Fill the 2 ways of index 0x00 with tags 0x00001 and 0x00002, dirty the first, then read tag 0x00003 at index 0x00:
  - wr_rq with ar_w_addr=0x0000_1000 and the dirty data;
  - then rd_rq with ar_r_addr=0x0000_3000;
  - the next miss in the same set evicts way 1.
- Hold ar_rd_ack low for 20 cycles -> rd_rq, ar_r_addr and stall stay constant. req_valid pulses during the stall are ignored.
- Assert reset while wr_rq=1 -> wr_rq=0 and stall=0 immediately. Counters read 0; the next read of the previously cached address misses.
- WAYS=1, INDEX_BITS=4, OFFSET_BITS=5: alternate reads 0x000 and 0x200 -> every access misses, ar_r_addr has bits [4:0]=0, data_out selects the correct word of the 256-bit line.
